// File: rtl/window_gen_3x3_stream.sv
// window_gen_3x3_stream: streaming 3x3 sliding-window generator.
// Raster-order pixels in; one 3x3 window out per pixel at row>=2, col>=2.
// Two IMG_W-deep line buffers feed the top two window rows.
// The window registers drive the outputs directly. They can only move on an
// accept, and no accept can happen while a window is stalled.
// Optional feature macro: WIN_COORD_EN adds out_row/out_col (window centre).
module window_gen_3x3_stream #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_win_0,
    output logic [DATA_W-1:0]          out_win_1,
    output logic [DATA_W-1:0]          out_win_2,
    output logic [DATA_W-1:0]          out_win_3,
    output logic [DATA_W-1:0]          out_win_4,
    output logic [DATA_W-1:0]          out_win_5,
    output logic [DATA_W-1:0]          out_win_6,
    output logic [DATA_W-1:0]          out_win_7,
    output logic [DATA_W-1:0]          out_win_8,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef WIN_COORD_EN
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic [$clog2(IMG_W)-1:0]   out_col,
`endif
    output logic                       out_last
);

    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);

    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] win [3][3];
    logic              accept;
    logic              emit;
    logic              row_end;
    logic              frame_end;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign row_end   = (col == CW'(IMG_W - 1));
    assign frame_end = row_end && (row == RW'(IMG_H - 1));
    assign emit      = (row >= RW'(2)) && (col >= CW'(2));

    assign out_win_0 = win[0][0];
    assign out_win_1 = win[0][1];
    assign out_win_2 = win[0][2];
    assign out_win_3 = win[1][0];
    assign out_win_4 = win[1][1];
    assign out_win_5 = win[1][2];
    assign out_win_6 = win[2][0];
    assign out_win_7 = win[2][1];
    assign out_win_8 = win[2][2];

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (row_end) begin
                col <= '0;
                row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers (rows r-1 and r-2) and window shift, advancing only on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < IMG_W; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
            for (int unsigned i = 0; i < 3; i++) begin
                for (int unsigned j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (accept) begin
            lb1[0] <= in_data;
            lb2[0] <= lb1[IMG_W-1];
            for (int unsigned i = 1; i < IMG_W; i++) begin
                lb1[i] <= lb1[i-1];
                lb2[i] <= lb2[i-1];
            end
            for (int unsigned i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb2[IMG_W-1];
            win[1][2] <= lb1[IMG_W-1];
            win[2][2] <= in_data;
        end
    end

    // Output handshake: load on accept, drop once consumed with nothing new
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= emit;
            out_last  <= emit && frame_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef WIN_COORD_EN
    // Window centre coordinates, captured together with each emitted window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_row <= '0;
            out_col <= '0;
        end else if (accept && emit) begin
            out_row <= row - RW'(1);
            out_col <= col - CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_window_gen_3x3_stream.sv
// Testbench for window_gen_3x3_stream (IMG_W=IMG_H=4, pixel = base + row*4 + col).
// Expected windows are queued when a frame is issued; a negedge monitor pops
// one entry per completed output handshake.
module tb_window_gen_3x3_stream;

    localparam int unsigned DW = 6;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;

    typedef struct packed {
        logic [9*DW-1:0] win;
        logic            last;
        logic [1:0]      row;
        logic [1:0]      col;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic [1:0]    out_row;
    logic [1:0]    out_col;
    logic [9*DW-1:0] win_flat;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    logic bp_arm = 1'b0;

    assign win_flat = {w8, w7, w6, w5, w4, w3, w2, w1, w0};

    window_gen_3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_win_0(w0), .out_win_1(w1), .out_win_2(w2),
        .out_win_3(w3), .out_win_4(w4), .out_win_5(w5),
        .out_win_6(w6), .out_win_7(w7), .out_win_8(w8),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef WIN_COORD_EN
        .out_row(out_row), .out_col(out_col),
`endif
        .out_last(out_last)
    );

`ifndef WIN_COORD_EN
    assign out_row = '0;
    assign out_col = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    function automatic exp_t mk(input int base, input int r, input int c);
        exp_t e;
        e = '0;
        for (int k = 0; k < 9; k++)
            e.win[k*DW +: DW] = DW'(base + (r - 2 + k / 3) * int'(W) + (c - 2 + k % 3));
        e.last = (r == int'(H) - 1) && (c == int'(W) - 1);
        e.row  = 2'(r - 1);
        e.col  = 2'(c - 1);
        return e;
    endfunction

    // Present one pixel and hold it until accepted (bounded)
    task automatic send(input logic [DW-1:0] v);
        int n;
        n = 0;
        in_data  = v;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue a full frame; optionally check first/last window timing and values
    task automatic send_frame(input int base, input bit gap, input bit spot,
                              input logic [9*DW-1:0] first_lit,
                              input logic [9*DW-1:0] last_lit);
        for (int r = 2; r < int'(H); r++)
            for (int c = 2; c < int'(W); c++)
                q.push_back(mk(base, r, c));
        for (int r = 0; r < int'(H); r++) begin
            for (int c = 0; c < int'(W); c++) begin
                send(DW'(base + r * int'(W) + c));
                if (spot && r == 2 && c == 1) chk("no_win_at_c1", 64'(out_valid), 64'd0);
                if (spot && r == 2 && c == 2) begin
                    chk("first_valid", 64'(out_valid), 64'd1);
                    chk("first_win", 64'(win_flat), 64'(first_lit));
                    chk("first_not_last", 64'(out_last), 64'd0);
                end
                if (spot && r == 3 && c == 3) begin
                    chk("last_win", 64'(win_flat), 64'(last_lit));
                    chk("last_flag", 64'(out_last), 64'd1);
                end
                if (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        repeat (6) @(posedge clk);
        #1;
        chk(name, 64'(q.size()), 64'd0);
        chk({name, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    // Scoreboard monitor: one pop per completed output handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_window", 64'(win_flat), 64'd0);
            end else begin
                e = q.pop_front();
                chk("sb_win", 64'(win_flat), 64'(e.win));
                chk("sb_last", 64'(out_last), 64'(e.last));
`ifdef WIN_COORD_EN
                chk("sb_coord", 64'({out_row, out_col}), 64'({e.row, e.col}));
`endif
            end
        end
    end

    // Backpressure: hold off the first window after arming for 3 cycles
    initial begin
        logic [9*DW-1:0] snap;
        forever begin
            @(posedge clk);
            #1;
            if (bp_arm && out_valid) begin
                out_ready = 1'b0;
                snap = win_flat;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_valid_held", 64'(out_valid), 64'd1);
                    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                    chk("bp_win_stable", 64'(win_flat), 64'(snap));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
                bp_arm = 1'b0;
            end
        end
    end

    initial begin
        logic [9*DW-1:0] f1_first, f1_last, f2_first, f2_last;
        f1_first = {6'd10, 6'd9, 6'd8, 6'd6, 6'd5, 6'd4, 6'd2, 6'd1, 6'd0};
        f1_last  = {6'd15, 6'd14, 6'd13, 6'd11, 6'd10, 6'd9, 6'd7, 6'd6, 6'd5};
        f2_first = {6'd26, 6'd25, 6'd24, 6'd22, 6'd21, 6'd20, 6'd18, 6'd17, 6'd16};
        f2_last  = {6'd31, 6'd30, 6'd29, 6'd27, 6'd26, 6'd25, 6'd23, 6'd22, 6'd21};

        // Reset state
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_win", 64'(win_flat), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // 1: continuous frame; also covers coordinates when enabled
        send_frame(0, 1'b0, 1'b1, f1_first, f1_last);
        drain("t1_drain");

        // 2: backpressure on the first window
        bp_arm = 1'b1;
        send_frame(0, 1'b0, 1'b0, f1_first, f1_last);
        drain("t2_drain");
        chk("t2_bp_done", 64'(bp_arm), 64'd0);

        // 3: gappy input
        send_frame(0, 1'b1, 1'b1, f1_first, f1_last);
        drain("t3_drain");

        // 4: reset mid-frame, then full frame
        for (int i = 0; i < 6; i++) send(DW'(i));
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", 64'(out_valid), 64'd0);
        chk("t4_rst_win", 64'(win_flat), 64'd0);
        @(posedge clk);
        #1;
        chk("t4_rst_hold_win", 64'(win_flat), 64'd0);
        chk("t4_rst_hold_last", 64'(out_last), 64'd0);
        rst = 1'b0;
        #1;
        chk("t4_in_ready", 64'(in_ready), 64'd1);
        send_frame(0, 1'b0, 1'b1, f1_first, f1_last);
        drain("t4_drain");

        // 5: back-to-back frames
        send_frame(0, 1'b0, 1'b1, f1_first, f1_last);
        send_frame(16, 1'b0, 1'b1, f2_first, f2_last);
        drain("t5_drain");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
